// File: rtl/mem_port_arbiter.sv
// Unified memory-port arbiter for the RV32I core: serialises IF fetches and MEM
// data accesses onto one bus, data stage first, dropping fetches killed by a flush.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   // instruction fetch requester
   input  logic                    ifReq,
   input  logic [ADDR_WIDTH-1:0]   ifAddr,
   output logic [DATA_WIDTH-1:0]   ifRdata,
   output logic                    ifValid,
   output logic                    ifStall,
   // data requester
   input  logic                    dmReq,
   input  logic                    dmWe,
   input  logic [DATA_WIDTH/8-1:0] dmBe,
   input  logic [ADDR_WIDTH-1:0]   dmAddr,
   input  logic [DATA_WIDTH-1:0]   dmWdata,
   output logic [DATA_WIDTH-1:0]   dmRdata,
   output logic                    dmValid,
   output logic                    dmStall,
   input  logic                    flush,
   // memory bus
   output logic                    memReq,
   output logic                    memWe,
   output logic [DATA_WIDTH/8-1:0] memBe,
   output logic [ADDR_WIDTH-1:0]   memAddr,
   output logic [DATA_WIDTH-1:0]   memWdata,
   input  logic                    memGnt,
   input  logic                    memRvalid,
   input  logic [DATA_WIDTH-1:0]   memRdata
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IF_ADDR = 3'd1,
      IF_DATA = 3'd2,
      IF_RESP = 3'd3,
      DM_ADDR = 3'd4,
      DM_DATA = 3'd5,
      DM_RESP = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic                  killed_q, killed_d;
   logic                  we_q, we_d;
   logic [BE_WIDTH-1:0]   be_q, be_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   // State, latched command fields and the shared read register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         killed_q <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         killed_q <= killed_d;
         we_q     <= we_d;
         be_q     <= be_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   // Next-state: data side wins in IDLE; a flush in IDLE suppresses the fetch latch
   always_comb begin
      state_d  = state_q;
      killed_d = killed_q;
      we_d     = we_q;
      be_d     = be_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;

      case (state_q)
         IDLE: begin
            if (dmReq) begin
               we_d    = dmWe;
               be_d    = dmBe;
               addr_d  = dmAddr;
               wdata_d = dmWdata;
               state_d = DM_ADDR;
            end else if (ifReq && !flush) begin
               we_d    = 1'b0;
               be_d    = '1;
               addr_d  = ifAddr;
               wdata_d = '0;
               state_d = IF_ADDR;
            end
         end
         IF_ADDR: begin
            if (flush) killed_d = 1'b1;
            if (memGnt) state_d = IF_DATA;
         end
         IF_DATA: begin
            if (flush) killed_d = 1'b1;
            if (memRvalid) begin
               rdata_d = memRdata;
               state_d = IF_RESP;
            end
         end
         IF_RESP: state_d = IDLE;
         DM_ADDR: begin
            if (memGnt) state_d = DM_DATA;
         end
         DM_DATA: begin
            if (memRvalid) begin
               rdata_d = memRdata;
               state_d = DM_RESP;
            end
         end
         DM_RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A killed fetch is forgotten once the bus transaction has drained
      if (state_d == IDLE) killed_d = 1'b0;
   end

   assign memReq   = (state_q == IF_ADDR) || (state_q == DM_ADDR);
   assign memWe    = we_q;
   assign memBe    = be_q;
   assign memAddr  = addr_q;
   assign memWdata = wdata_q;

   assign ifRdata  = rdata_q;
   assign dmRdata  = rdata_q;
   // flush in the response cycle still drops the fetch
   assign ifValid  = (state_q == IF_RESP) && !killed_q && !flush;
   assign dmValid  = (state_q == DM_RESP);
   assign ifStall  = ifReq && !ifValid;
   assign dmStall  = dmReq && !dmValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions whose timing is predicted from the per-transaction bus wait counts.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          ifReq, ifValid, ifStall;
   logic [AW-1:0] ifAddr;
   logic [DW-1:0] ifRdata;
   logic          dmReq, dmWe, dmValid, dmStall;
   logic [BW-1:0] dmBe;
   logic [AW-1:0] dmAddr;
   logic [DW-1:0] dmWdata, dmRdata;
   logic          flush;
   logic          memReq, memWe, memGnt, memRvalid;
   logic [BW-1:0] memBe;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWdata, memRdata;

   int vectors     = 0;
   int miscompares = 0;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifValid(ifValid), .ifStall(ifStall),
      .dmReq(dmReq), .dmWe(dmWe), .dmBe(dmBe), .dmAddr(dmAddr), .dmWdata(dmWdata),
      .dmRdata(dmRdata), .dmValid(dmValid), .dmStall(dmStall),
      .flush(flush),
      .memReq(memReq), .memWe(memWe), .memBe(memBe), .memAddr(memAddr), .memWdata(memWdata),
      .memGnt(memGnt), .memRvalid(memRvalid), .memRdata(memRdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction: request in cycle 0, grant after gw waits, response rw cycles later.
   task automatic run_txn(input bit dm, input bit we, input logic [BW-1:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rdata, input int gw, input int rw,
                          input int flush_at, input bit if_bg, input logic [AW-1:0] bg_addr);
      int   total;
      int   gnt_c;
      int   rv_c;
      bit   killed;
      bit   exp_req, exp_ifv, exp_dmv;
      total  = 3 + gw + rw;
      gnt_c  = 1 + gw;
      rv_c   = 2 + gw + rw;
      killed = 1'b0;
      for (int c = 0; c <= total; c++) begin
         dmReq     = dm;
         dmWe      = we;
         dmBe      = be;
         dmAddr    = addr;
         dmWdata   = wdata;
         ifReq     = !dm || if_bg;
         ifAddr    = dm ? bg_addr : addr;
         flush     = (c == flush_at);
         memGnt    = (c == gnt_c) || ((c == 0 || c > gnt_c) && $urandom_range(0, 1) == 1);
         memRvalid = (c == rv_c) || ((c <= gnt_c || c == total) && $urandom_range(0, 1) == 1);
         memRdata  = (c == rv_c) ? rdata : DW'($urandom);
         #1;
         if (!dm && flush && c >= 1 && c < total) killed = 1'b1;
         exp_req = (c >= 1) && (c <= gnt_c);
         exp_dmv = dm && (c == total);
         exp_ifv = !dm && (c == total) && !killed && !flush;
         chk("memReq", 32'(memReq), 32'(exp_req));
         if (exp_req) begin
            chk("memAddr",  memAddr, addr);
            chk("memWe",    32'(memWe), 32'(dm ? we : 1'b0));
            chk("memBe",    32'(memBe), 32'(dm ? be : {BW{1'b1}}));
            chk("memWdata", memWdata, dm ? wdata : 32'h0);
         end
         chk("ifValid", 32'(ifValid), 32'(exp_ifv));
         chk("dmValid", 32'(dmValid), 32'(exp_dmv));
         chk("ifStall", 32'(ifStall), 32'(ifReq && !exp_ifv));
         chk("dmStall", 32'(dmStall), 32'(dmReq && !exp_dmv));
         if (c == total) begin
            chk("ifRdata", ifRdata, rdata);
            chk("dmRdata", dmRdata, rdata);
         end
         @(negedge clk);
      end
   endtask

   task automatic idle_cycle();
      ifReq     = 1'b0;
      dmReq     = 1'b0;
      flush     = 1'($urandom_range(0, 1));
      memGnt    = 1'($urandom_range(0, 1));
      memRvalid = 1'($urandom_range(0, 1));
      memRdata  = DW'($urandom);
      #1;
      chk("idle memReq",  32'(memReq),  32'h0);
      chk("idle ifValid", 32'(ifValid), 32'h0);
      chk("idle dmValid", 32'(dmValid), 32'h0);
      chk("idle ifStall", 32'(ifStall), 32'h0);
      chk("idle dmStall", 32'(dmStall), 32'h0);
      @(negedge clk);
   endtask

   initial begin
      logic [AW-1:0] bg;
      logic [AW-1:0] a;
      bit            pend_if;
      int            gw, rw, fa, tot;
      bit            d;

      rst = 1'b1; ifReq = 1'b1; ifAddr = '0; dmReq = 1'b0; dmWe = 1'b0; dmBe = '0;
      dmAddr = '0; dmWdata = '0; flush = 1'b0; memGnt = 1'b0; memRvalid = 1'b0; memRdata = '0;
      @(negedge clk);
      #1;
      chk("rst memReq",  32'(memReq),  32'h0);
      chk("rst memBe",   32'(memBe),   32'h0);
      chk("rst memAddr", memAddr,      32'h0);
      chk("rst ifValid", 32'(ifValid), 32'h0);
      chk("rst ifRdata", ifRdata,      32'h0);
      chk("rst ifStall", 32'(ifStall), 32'h1);
      chk("rst dmStall", 32'(dmStall), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle_cycle();

      // zero-wait fetch
      run_txn(0, 0, '0, 32'h100, '0, 32'hDEADBEEF, 0, 0, -1, 0, '0);
      idle_cycle();
      // simultaneous requests: load first, then the held fetch
      run_txn(1, 0, 4'hF, 32'h200, 32'h0, 32'h0BAD_F00D, 0, 0, -1, 1, 32'h104);
      run_txn(0, 0, '0, 32'h104, '0, 32'h0000_0013, 0, 0, -1, 0, '0);
      idle_cycle();
      // store with two grant waits and three response waits
      run_txn(1, 1, 4'b0011, 32'h40, 32'h1234, 32'h0, 2, 3, -1, 0, '0);
      idle_cycle();
      // flush in IF_DATA, then the redirected fetch
      run_txn(0, 0, '0, 32'h2F0, '0, 32'h1111_1111, 1, 2, 4, 0, '0);
      run_txn(0, 0, '0, 32'h300, '0, 32'h2222_2222, 0, 1, -1, 0, '0);
      // flush coinciding with the response cycle
      run_txn(0, 0, '0, 32'h304, '0, 32'h3333_3333, 1, 1, 5, 0, '0);
      idle_cycle();
      // flush in IDLE delays the fetch latch by one cycle
      ifReq = 1'b1; ifAddr = 32'h400; flush = 1'b1; memGnt = 1'b0; memRvalid = 1'b0;
      #1;
      chk("idleflush memReq", 32'(memReq),  32'h0);
      chk("idleflush ifStall", 32'(ifStall), 32'h1);
      @(negedge clk);
      run_txn(0, 0, '0, 32'h400, '0, 32'h4444_4444, 0, 0, -1, 0, '0);
      idle_cycle();

      // randomized transactions
      pend_if = 1'b0;
      bg      = '0;
      for (int n = 0; n < 150; n++) begin
         gw = int'($urandom_range(0, 3));
         rw = int'($urandom_range(0, 3));
         tot = 3 + gw + rw;
         if (pend_if) d = 1'b0;
         else d = 1'($urandom_range(0, 1));
         fa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 32'(tot))) : -1;
         a  = pend_if ? bg : ($urandom & 32'hFFFF_FFFC);
         if (d) begin
            bg = $urandom & 32'hFFFF_FFFC;
            pend_if = 1'($urandom_range(0, 1));
            run_txn(1, 1'($urandom_range(0, 1)), BW'($urandom), a, DW'($urandom), DW'($urandom),
                    gw, rw, fa, pend_if, bg);
         end else begin
            pend_if = 1'b0;
            run_txn(0, 0, '0, a, '0, DW'($urandom), gw, rw, fa, 0, '0);
         end
         if (!pend_if && $urandom_range(0, 3) == 0) idle_cycle();
      end
      idle_cycle();

      // reset in DM_DATA of a store; a late response must be ignored
      dmReq = 1'b1; dmWe = 1'b1; dmBe = 4'hF; dmAddr = 32'h500; dmWdata = 32'hCAFE;
      ifReq = 1'b0; flush = 1'b0; memGnt = 1'b0; memRvalid = 1'b0;
      @(negedge clk);
      memGnt = 1'b1;
      @(negedge clk);
      memGnt = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst memReq",   32'(memReq),   32'h0);
      chk("arst memWe",    32'(memWe),    32'h0);
      chk("arst memBe",    32'(memBe),    32'h0);
      chk("arst memAddr",  memAddr,       32'h0);
      chk("arst memWdata", memWdata,      32'h0);
      chk("arst dmValid",  32'(dmValid),  32'h0);
      chk("arst dmRdata",  dmRdata,       32'h0);
      chk("arst dmStall",  32'(dmStall),  32'h1);
      dmReq = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         memRvalid = (c == 2);
         memRdata  = 32'h5555_AAAA;
         #1;
         chk("postrst memReq",  32'(memReq),  32'h0);
         chk("postrst dmValid", 32'(dmValid), 32'h0);
         chk("postrst dmRdata", dmRdata,      32'h0);
         @(negedge clk);
      end
      run_txn(0, 0, '0, 32'h600, '0, 32'h6666_6666, 0, 0, -1, 0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
